sobel_edge_core: RTL and testbench
==================================

Name: sobel_edge_core

Overview:
Downstream consumer of the PixelWindow 3x3 window stage in the camera-to-CNN read path. Converts each of the 9 RGB888 window pixels to 8-bit luma, computes the Sobel Gx/Gy gradients, and outputs the saturated magnitude |Gx|+|Gy| as one 8-bit edge pixel per window. The pipeline advances only on wEnClk pixel-enable cycles, matching the 6.25 MHz enable cadence on the 100 MHz clock.

Parameters:
PIX_W, 24, window pixel width; RGB888 packed as {R[23:16],G[15:8],B[7:0]}
FRAME_PIX, 130560, output pixels per frame (480x272); counter terminal value
THRESH, 8'd64, binarisation threshold; used only when SOBEL_THRESH_EN is defined

Ports:
iClk  input  1  100 MHz system clock
iRst  input  1  asynchronous reset, active-high
wEnClk  input  1  pixel enable; pipeline advances only when 1
wFgPixelValid  input  1  window valid from PixelWindow
wPixel00..wPixel22  input  PIX_W each (9 ports)  3x3 window; row index first, column index second
wConvolDone  input  1  end-of-frame flag from PixelWindow
wFgSobelValid  output  1  edge pixel valid (level; consumers qualify with wEnClk)
wSobelPixel  output  8  edge magnitude, or binarised value
wOutCnt  output  17  number of edge pixels emitted in the current frame
wSobelDone  output  1  frame-complete pulse, one enabled cycle wide

Behaviour:
- Reset (async, iRst=1): all pipeline data and valid registers = 0; wFgSobelValid=0, wSobelPixel=0, wOutCnt=0, wSobelDone=0. Reset mid-frame drops all in-flight pixels. Nothing is emitted until a new valid window arrives after reset is released.
- All registers hold their value when wEnClk=0. There is no backpressure.
- S1 (luma): Y = (77*R + 150*G + 29*B) >> 8 for each of the 9 pixels. The 16-bit intermediate is truncated to 8 bits. Gray pixel R=G=B=v gives Y=v.
- S2 (gradient), signed 11-bit:
  Gx = (Y02 + 2*Y12 + Y22) - (Y00 + 2*Y10 + Y20)
  Gy = (Y20 + 2*Y21 + Y22) - (Y00 + 2*Y01 + Y02)
  Range is ±1020.
- S3: |Gx| and |Gy|, 10-bit unsigned each.
- S4: sum is 11-bit; values above 255 saturate to 255. Result is written to wSobelPixel.
- Latency: exactly 4 enabled cycles from valid input to wFgSobelValid.
- Valid handling: a 4-deep valid shift register advances on wEnClk. wFgSobelValid = stage-4 valid.
- Counter: wOutCnt increments on each enabled cycle that loads a stage-4 valid. At FRAME_PIX it holds (saturates) and does not wrap.
- Done: wConvolDone is carried through a 4-deep done shift register aligned with the data. Stage-4 done drives wSobelDone for one enabled cycle. The following enabled cycle clears wOutCnt to 0.
- Simultaneous valid and done at stage 4: the pixel is counted first. wOutCnt shows the final count during the wSobelDone cycle, then clears.
- Done arriving with wOutCnt != FRAME_PIX: wSobelDone still pulses and the counter still clears. The mismatch is visible in wOutCnt.
- Invalid windows still flow through the data path, but wFgSobelValid stays 0 for them.

Optional Feature:
SOBEL_THRESH_EN
- Defined: one extra compare at S4, with no added latency. wSobelPixel = 8'hFF if the saturated magnitude >= THRESH, else 8'h00.
- Undefined: wSobelPixel carries the raw saturated magnitude, and THRESH is unused.

Decomposition:
- Package sobel_pkg: luma coefficients (77/150/29), LUMA_W=8, GRAD_W=11, MAG_W=8, FRAME_PIX default, CNT_W=17.
- One sub-module, sobel_rgb2luma: a combinational/registered S1 converter instantiated 9 times, with an enable input.
- Gradient, abs, saturate, counter and done logic stay in sobel_edge_core.

Test Plan:
- Uniform window, all pixels 24'h808080, wEnClk every 16th cycle -> wSobelPixel=0 exactly 4 enabled cycles later, wFgSobelValid=1.
- Vertical edge: column 0 = 24'h000000, column 2 = 24'hFFFFFF, centre column either value -> Gx=1020, Gy=0, wSobelPixel=8'hFF (saturated).
- Gradient: column 0 gray 10, column 2 gray 20 -> Gx=40, wSobelPixel=8'd40. With SOBEL_THRESH_EN and THRESH=64 -> 8'h00. Same case with THRESH=40 -> 8'hFF.
- Stall: hold wEnClk=0 for 50 cycles mid-stream -> all outputs frozen, no extra count increment. Ordering preserved on resume.
- Frame: 130560 valid windows, then wConvolDone aligned with the last window -> wOutCnt=130560 during a single enabled-cycle wSobelDone pulse, then 0 on the next enabled cycle.
- Assert iRst asynchronously with 3 valid pixels in flight -> outputs 0 immediately. After release, no spurious wFgSobelValid and wOutCnt=0.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel edge core.
// Luma weights sum to 256 so a gray pixel maps to itself.
package sobel_pkg;

    localparam int PIX_W         = 24;
    localparam int LUMA_W        = 8;
    localparam int GRAD_W        = 11;
    localparam int ABS_W         = 10;
    localparam int MAG_W         = 8;
    localparam int CNT_W         = 17;
    localparam int FRAME_PIX_DEF = 130560;

    localparam logic [15:0] C_R = 16'd77;
    localparam logic [15:0] C_G = 16'd150;
    localparam logic [15:0] C_B = 16'd29;

    function automatic logic signed [GRAD_W-1:0] sx(
        input logic [LUMA_W-1:0] v
    );
        return $signed({{(GRAD_W-LUMA_W){1'b0}}, v});
    endfunction

endpackage

// File: rtl/sobel_edge_core_if.sv
// Window-in / edge-pixel-out bundle between PixelWindow and the Sobel core.
// master drives the window side, slave is the core.
interface sobel_edge_core_if;
    import sobel_pkg::*;

    logic               wEnClk;
    logic               wFgPixelValid;
    logic [PIX_W-1:0]   wPixel00, wPixel01, wPixel02;
    logic [PIX_W-1:0]   wPixel10, wPixel11, wPixel12;
    logic [PIX_W-1:0]   wPixel20, wPixel21, wPixel22;
    logic               wConvolDone;
    logic               wFgSobelValid;
    logic [MAG_W-1:0]   wSobelPixel;
    logic [CNT_W-1:0]   wOutCnt;
    logic               wSobelDone;

    modport master (
        output wEnClk, wFgPixelValid, wConvolDone,
        output wPixel00, wPixel01, wPixel02,
        output wPixel10, wPixel11, wPixel12,
        output wPixel20, wPixel21, wPixel22,
        input  wFgSobelValid, wSobelPixel, wOutCnt, wSobelDone
    );

    modport slave (
        input  wEnClk, wFgPixelValid, wConvolDone,
        input  wPixel00, wPixel01, wPixel02,
        input  wPixel10, wPixel11, wPixel12,
        input  wPixel20, wPixel21, wPixel22,
        output wFgSobelValid, wSobelPixel, wOutCnt, wSobelDone
    );

endinterface

// File: rtl/sobel_rgb2luma.sv
// Registered RGB888 to 8-bit luma converter (first pipeline stage).
module sobel_rgb2luma
    import sobel_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [PIX_W-1:0]  pix_i,
    output logic [LUMA_W-1:0] y_o
);

    logic [15:0]       sum;
    logic [LUMA_W-1:0] y_d, y_q;

    always_comb begin
        sum = C_R * {8'd0, pix_i[23:16]}
            + C_G * {8'd0, pix_i[15:8]}
            + C_B * {8'd0, pix_i[7:0]};
        y_d = LUMA_W'(sum >> 8);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_q <= '0;
        end else if (en_i) begin
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/sobel_edge_core.sv
// 4-stage Sobel edge core: luma, gradient, abs, saturated magnitude.
// Define SOBEL_THRESH_EN to binarise the output against THRESH.
module sobel_edge_core
    import sobel_pkg::*;
#(
    parameter int FRAME_PIX = FRAME_PIX_DEF
`ifdef SOBEL_THRESH_EN
    , parameter logic [MAG_W-1:0] THRESH = 8'd64
`endif
) (
    input logic              iClk,
    input logic              iRst,
    sobel_edge_core_if.slave bus
);

    logic [PIX_W-1:0]  pix [9];
    logic [LUMA_W-1:0] y   [9];

    assign pix[0] = bus.wPixel00;
    assign pix[1] = bus.wPixel01;
    assign pix[2] = bus.wPixel02;
    assign pix[3] = bus.wPixel10;
    assign pix[4] = bus.wPixel11;
    assign pix[5] = bus.wPixel12;
    assign pix[6] = bus.wPixel20;
    assign pix[7] = bus.wPixel21;
    assign pix[8] = bus.wPixel22;

    for (genvar i = 0; i < 9; i++) begin : g_luma
        sobel_rgb2luma u_luma (
            .clk_i (iClk),
            .rst_i (iRst),
            .en_i  (bus.wEnClk),
            .pix_i (pix[i]),
            .y_o   (y[i])
        );
    end

    logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
    logic [ABS_W-1:0]         ax_d, ay_d, ax_q, ay_q;
    logic [ABS_W:0]           sum;
    logic [MAG_W-1:0]         mag;
    logic [MAG_W-1:0]         pix_d, pix_q;
    logic [3:0]               v_d, v_q;
    logic [3:0]               dn_d, dn_q;
    logic [CNT_W-1:0]         cnt_base, cnt_d, cnt_q;

    always_comb begin
        gx_d = (sx(y[2]) + (sx(y[5]) <<< 1) + sx(y[8]))
             - (sx(y[0]) + (sx(y[3]) <<< 1) + sx(y[6]));
        gy_d = (sx(y[6]) + (sx(y[7]) <<< 1) + sx(y[8]))
             - (sx(y[0]) + (sx(y[1]) <<< 1) + sx(y[2]));
        ax_d = ABS_W'(gx_q[GRAD_W-1] ? -gx_q : gx_q);
        ay_d = ABS_W'(gy_q[GRAD_W-1] ? -gy_q : gy_q);
        sum  = {1'b0, ax_q} + {1'b0, ay_q};
        mag  = (|sum[ABS_W:MAG_W]) ? {MAG_W{1'b1}} : sum[MAG_W-1:0];
`ifdef SOBEL_THRESH_EN
        pix_d = (mag >= THRESH) ? {MAG_W{1'b1}} : '0;
`else
        pix_d = mag;
`endif
        v_d  = {v_q[2:0], bus.wFgPixelValid};
        dn_d = {dn_q[2:0], bus.wConvolDone};
    end

    // A visible done clears the count; a pixel entering stage 4 counts
    always_comb begin
        cnt_base = dn_q[3] ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (v_q[2] && cnt_base != CNT_W'(FRAME_PIX)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            gx_q  <= '0;
            gy_q  <= '0;
            ax_q  <= '0;
            ay_q  <= '0;
            pix_q <= '0;
            v_q   <= '0;
            dn_q  <= '0;
            cnt_q <= '0;
        end else if (bus.wEnClk) begin
            gx_q  <= gx_d;
            gy_q  <= gy_d;
            ax_q  <= ax_d;
            ay_q  <= ay_d;
            pix_q <= pix_d;
            v_q   <= v_d;
            dn_q  <= dn_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.wFgSobelValid = v_q[3];
    assign bus.wSobelPixel   = pix_q;
    assign bus.wOutCnt       = cnt_q;
    assign bus.wSobelDone    = dn_q[3];

endmodule

// File: tb/tb_sobel_edge_core.sv
// Randomised bench for sobel_edge_core against a queue-based window model.
// Frame length is shortened through FRAME_PIX to keep the run brief.
module tb_sobel_edge_core;
    import sobel_pkg::*;

    localparam int FP = 48;

    typedef struct {
        logic [7:0] pix;
        logic       v;
        logic       d;
    } exp_t;

    logic iClk = 1'b0;
    logic iRst;
    always #5 iClk = ~iClk;

    sobel_edge_core_if bus();

    sobel_edge_core #(.FRAME_PIX(FP)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    logic [23:0] win [9];
    exp_t        pipe [$];
    exp_t        cur;
    int          cnt_m;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic int luma(input logic [23:0] p);
        return (77 * int'(p[23:16]) + 150 * int'(p[15:8])
              + 29 * int'(p[7:0])) / 256;
    endfunction

    function automatic logic [7:0] ref_pix();
        int l [9];
        int gx, gy, m;
        for (int i = 0; i < 9; i++) l[i] = luma(win[i]);
        gx = (l[2] + 2 * l[5] + l[8]) - (l[0] + 2 * l[3] + l[6]);
        gy = (l[6] + 2 * l[7] + l[8]) - (l[0] + 2 * l[1] + l[2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
        return (m >= 64) ? 8'hFF : 8'h00;
`else
        return 8'(m);
`endif
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid", int'(bus.wFgSobelValid), int'(cur.v));
        chk("pixel", int'(bus.wSobelPixel), int'(cur.pix));
        chk("count", int'(bus.wOutCnt), cnt_m);
        chk("done", int'(bus.wSobelDone), int'(cur.d));
    endtask

    task automatic reset_model();
        pipe.delete();
        repeat (3) pipe.push_back('{pix: 8'd0, v: 1'b0, d: 1'b0});
        cur   = '{pix: 8'd0, v: 1'b0, d: 1'b0};
        cnt_m = 0;
    endtask

    // Each enabled edge accepts one window; it surfaces 4 enables later
    task automatic model_step();
        exp_t n;
        logic prev_d;
        n.pix = ref_pix();
        n.v   = bus.wFgPixelValid;
        n.d   = bus.wConvolDone;
        pipe.push_back(n);
        prev_d = cur.d;
        cur    = pipe.pop_front();
        if (prev_d) cnt_m = 0;
        if (cur.v && cnt_m < FP) cnt_m++;
    endtask

    task automatic cycle(input logic en);
        bus.wEnClk = en;
        @(posedge iClk);
        if (en) model_step();
        #1;
        check_all();
    endtask

    task automatic send(input int gap, input logic v, input logic d);
        bus.wPixel00 = win[0]; bus.wPixel01 = win[1];
        bus.wPixel02 = win[2]; bus.wPixel10 = win[3];
        bus.wPixel11 = win[4]; bus.wPixel12 = win[5];
        bus.wPixel20 = win[6]; bus.wPixel21 = win[7];
        bus.wPixel22 = win[8];
        bus.wFgPixelValid = v;
        bus.wConvolDone   = d;
        repeat (gap) cycle(1'b0);
        cycle(1'b1);
    endtask

    task automatic set_cols(input logic [23:0] c0, c1, c2);
        for (int r = 0; r < 3; r++) begin
            win[r * 3]     = c0;
            win[r * 3 + 1] = c1;
            win[r * 3 + 2] = c2;
        end
    endtask

    task automatic rand_win();
        for (int i = 0; i < 9; i++) begin
            if ($urandom_range(0, 3) == 0)
                win[i] = $urandom_range(0, 1) ? 24'hFFFFFF : 24'h0;
            else
                win[i] = 24'($urandom);
        end
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            rand_win();
            send($urandom_range(0, 2), 1'b1, i == n - 1);
        end
        for (int i = 0; i < 6; i++) begin
            rand_win();
            send($urandom_range(0, 2), 1'b0, 1'b0);
        end
    endtask

    initial begin
        iRst = 1'b1;
        bus.wEnClk = 1'b0;
        bus.wFgPixelValid = 1'b0;
        bus.wConvolDone = 1'b0;
        set_cols(24'h0, 24'h0, 24'h0);
        send(0, 1'b0, 1'b0);
        reset_model();
        repeat (3) @(posedge iClk);
        #1;
        check_all();
        @(negedge iClk);
        iRst = 1'b0;

        set_cols(24'h808080, 24'h808080, 24'h808080);
        send(15, 1'b1, 1'b0);
        set_cols(24'h000000, 24'hFFFFFF, 24'hFFFFFF);
        send(15, 1'b1, 1'b0);
        set_cols(24'h000000, 24'h000000, 24'hFFFFFF);
        send(15, 1'b1, 1'b0);
        set_cols(24'h0A0A0A, 24'h0F0F0F, 24'h141414);
        send(15, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(15, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            rand_win();
            send(i == 100 ? 50 : $urandom_range(0, 3),
                 $urandom_range(0, 4) != 0, i == 199);
        end
        for (int i = 0; i < 6; i++) send(1, 1'b0, 1'b0);

        frame(FP);
        frame(FP + 5);
        frame(20);

        for (int i = 0; i < 6; i++) begin
            rand_win();
            send($urandom_range(0, 1), 1'b1, 1'b0);
        end
        bus.wEnClk = 1'b0;
        #3;
        iRst = 1'b1;
        reset_model();
        #1;
        check_all();
        @(negedge iClk);
        iRst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rand_win();
            send($urandom_range(0, 2), 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            rand_win();
            send($urandom_range(0, 2), 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
